pipe_stage_skid: RTL

- Parametrised pipeline-stage register, successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a DATA_W data payload plus a CTRL_W control bundle with valid/ready handshake, a 2-entry skid buffer (full throughput under back-pressure), flush (bubble insertion) and an occupancy count.
- Instantiated between any two pipeline stages in place of hand-written stage registers.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_entry_reg.sv | 54 +++++
 rtl/pipe_stage_skid.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and constants.
//   ex_mem_ctrl_t : packed EX/MEM control bundle carried alongside the payload
//   EX_MEM_CTRL_W : width of that bundle (default CTRL_W of a stage register)
//   CTRL_BUBBLE   : control value presented while a stage holds no valid entry
//   OCC_W         : width of the occupancy count (0..2)
package pipe_pkg;

    typedef struct packed {
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
    } ex_mem_ctrl_t;

    localparam int unsigned EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam ex_mem_ctrl_t CTRL_BUBBLE  = '0;
    localparam int unsigned OCC_W         = 2;

endpackage

// File: rtl/pipe_entry_reg.sv
// Single valid + data + ctrl storage entry.
// Ports:
//   clk, rst        : clock, async active-low reset
//   i_load, i_clear : capture i_data/i_ctrl and set valid / drop the entry
//   i_data, i_ctrl  : values to capture on load
//   o_valid, o_data, o_ctrl : registered entry contents
// A cleared entry always shows bubble control; its data is zeroed only when
// ZERO_ON_CLEAR is set, otherwise it keeps the last captured word.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W        = 69,
    parameter int unsigned CTRL_W        = EX_MEM_CTRL_W,
    parameter bit          ZERO_ON_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Clear wins over load; the steering logic never requests both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= CTRL_W'(CTRL_BUBBLE);
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_W'(CTRL_BUBBLE);
            if (ZERO_ON_CLEAR) begin
                r_data <= '0;
            end
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, flush and occupancy.
// Ports:
//   clk, rst              : clock, async active-low reset
//   flush                 : kill held entries and the current input at this edge
//   in_valid/in_ready     : upstream handshake (in_ready is combinational)
//   in_data, in_ctrl      : upstream payload and control bundle
//   out_valid/out_ready   : downstream handshake
//   out_data, out_ctrl    : registered payload/control (ctrl is 0 on bubbles)
//   occupancy             : number of held entries, 0..2
// The main entry drives the outputs; the skid entry absorbs one word when the
// downstream stalls so upstream sees in_ready a cycle late without data loss.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W              = 69,
    parameter int unsigned CTRL_W              = EX_MEM_CTRL_W,
    parameter bit          ZERO_DATA_ON_BUBBLE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [OCC_W-1:0]  occupancy
);

    logic              w_m_valid;
    logic [DATA_W-1:0] w_m_data;
    logic [CTRL_W-1:0] w_m_ctrl;
    logic              w_s_valid;
    logic [DATA_W-1:0] w_s_data;
    logic [CTRL_W-1:0] w_s_ctrl;

    logic              w_accept;
    logic              w_send;
    logic              w_m_load;
    logic              w_m_clear;
    logic              w_m_from_skid;
    logic              w_s_load;
    logic              w_s_clear;
    logic              w_m_valid_next;
    logic              w_s_valid_next;
    logic [DATA_W-1:0] w_m_d;
    logic [CTRL_W-1:0] w_m_c;
    logic [OCC_W-1:0]  r_occ;

    // Skid is only ever filled while main is full, so a free skid slot
    // means the stage can take a word regardless of downstream state.
    assign in_ready = !w_s_valid;
    assign w_accept = in_valid && in_ready && !flush;
    assign w_send   = w_m_valid && out_ready;

    // Steering of the two entries for the coming edge.
    always_comb begin
        w_m_load      = 1'b0;
        w_m_clear     = 1'b0;
        w_m_from_skid = 1'b0;
        w_s_load      = 1'b0;
        w_s_clear     = 1'b0;
        if (flush) begin
            w_m_clear = 1'b1;
            w_s_clear = 1'b1;
        end else if (!w_m_valid) begin
            w_m_load = w_accept;
        end else if (w_send) begin
            if (w_s_valid) begin
                w_m_load      = 1'b1;
                w_m_from_skid = 1'b1;
                w_s_clear     = 1'b1;
            end else if (w_accept) begin
                w_m_load = 1'b1;
            end else begin
                w_m_clear = 1'b1;
            end
        end else begin
            w_s_load = w_accept;
        end
    end

    assign w_m_d = w_m_from_skid ? w_s_data : in_data;
    assign w_m_c = w_m_from_skid ? w_s_ctrl : in_ctrl;

    // Valid bits as they will be after the edge, for the occupancy count.
    always_comb begin
        w_m_valid_next = w_m_valid;
        w_s_valid_next = w_s_valid;
        if (w_m_clear) begin
            w_m_valid_next = 1'b0;
        end else if (w_m_load) begin
            w_m_valid_next = 1'b1;
        end
        if (w_s_clear) begin
            w_s_valid_next = 1'b0;
        end else if (w_s_load) begin
            w_s_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ <= '0;
        end else begin
            r_occ <= {w_m_valid_next & w_s_valid_next, w_m_valid_next ^ w_s_valid_next};
        end
    end

    pipe_entry_reg #(
        .DATA_W        (DATA_W),
        .CTRL_W        (CTRL_W),
        .ZERO_ON_CLEAR (ZERO_DATA_ON_BUBBLE)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_m_load),
        .i_clear (w_m_clear),
        .i_data  (w_m_d),
        .i_ctrl  (w_m_c),
        .o_valid (w_m_valid),
        .o_data  (w_m_data),
        .o_ctrl  (w_m_ctrl)
    );

    pipe_entry_reg #(
        .DATA_W        (DATA_W),
        .CTRL_W        (CTRL_W),
        .ZERO_ON_CLEAR (1'b1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_s_load),
        .i_clear (w_s_clear),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_valid (w_s_valid),
        .o_data  (w_s_data),
        .o_ctrl  (w_s_ctrl)
    );

    assign out_valid = w_m_valid;
    assign out_data  = w_m_data;
    assign out_ctrl  = w_m_ctrl;
    assign occupancy = r_occ;

endmodule
